// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the two-requester AXI3 read arbiter.
package axi_arb_pkg;

    localparam int unsigned INFO_W = 18;

    // arinfo = {arlen[3:0], arsize[2:0], arburst[1:0], arlock[1:0], arcache[3:0], arprot[2:0]}
    localparam int unsigned AR_PROT_OFF  = 0;
    localparam int unsigned AR_CACHE_OFF = 3;
    localparam int unsigned AR_LOCK_OFF  = 7;
    localparam int unsigned AR_BURST_OFF = 9;
    localparam int unsigned AR_SIZE_OFF  = 11;
    localparam int unsigned AR_LEN_OFF   = 14;
    localparam int unsigned AR_LEN_W     = 4;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_e;

endpackage

// File: rtl/axi_read_arbiter_arb_pick.sv
// Combinational winner select between the two read requesters.
// AXI_ARB_RR_EN: round-robin on ties using last_grant; otherwise requester 0 has fixed priority.
module arb_pick (
    input  logic req0_i,
    input  logic req1_i,
`ifdef AXI_ARB_RR_EN
    input  logic last_grant_i,
`endif
    output logic grant_c_o
);

    always_comb begin
        grant_c_o = 1'b0;
`ifdef AXI_ARB_RR_EN
        if (req0_i && req1_i) begin
            grant_c_o = ~last_grant_i;
        end else begin
            grant_c_o = req1_i;
        end
`else
        grant_c_o = ~req0_i & req1_i;
`endif
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// Two-requester AXI3 read arbiter (0 = dcache, 1 = icache), one transaction at a time.
// AXI_ARB_RR_EN selects round-robin arbitration; default build is fixed priority to requester 0.
module axi_read_arbiter #(
    parameter int unsigned ID_W   = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned INFO_W = axi_arb_pkg::INFO_W
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ID_W-1:0]   s0_arid,
    input  logic [ADDR_W-1:0] s0_araddr,
    input  logic [INFO_W-1:0] s0_arinfo,
    input  logic              s0_arvalid,
    output logic              s0_arready,
    output logic [ID_W-1:0]   s0_rid,
    output logic [DATA_W-1:0] s0_rdata,
    output logic [1:0]        s0_rresp,
    output logic              s0_rlast,
    output logic              s0_rvalid,
    input  logic              s0_rready,

    input  logic [ID_W-1:0]   s1_arid,
    input  logic [ADDR_W-1:0] s1_araddr,
    input  logic [INFO_W-1:0] s1_arinfo,
    input  logic              s1_arvalid,
    output logic              s1_arready,
    output logic [ID_W-1:0]   s1_rid,
    output logic [DATA_W-1:0] s1_rdata,
    output logic [1:0]        s1_rresp,
    output logic              s1_rlast,
    output logic              s1_rvalid,
    input  logic              s1_rready,

    output logic [ID_W-1:0]   m_arid,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [INFO_W-1:0] m_arinfo,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [ID_W-1:0]   m_rid,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rlast,
    input  logic              m_rvalid,
    output logic              m_rready,

    output logic              busy
);

    import axi_arb_pkg::*;

    arb_state_e state_q;
    logic       grant_q;
    logic       arvalid_q;
    logic       busy_q;
    logic       pick_c;
    logic       any_req_c;
    logic       sel0_c;
    logic       sel1_c;
`ifdef AXI_ARB_RR_EN
    logic       last_grant_q;
`endif

    assign any_req_c = s0_arvalid | s1_arvalid;

    arb_pick u_pick (
        .req0_i       (s0_arvalid),
`ifdef AXI_ARB_RR_EN
        .last_grant_i (last_grant_q),
`endif
        .req1_i       (s1_arvalid),
        .grant_c_o    (pick_c)
    );

    // Grant is frozen from IDLE until the last R beat; AR valid holds until the handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            arvalid_q    <= 1'b0;
            busy_q       <= 1'b0;
`ifdef AXI_ARB_RR_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req_c) begin
                        state_q   <= ADDR;
                        grant_q   <= pick_c;
                        arvalid_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                ADDR: begin
                    if (arvalid_q && m_arready) begin
                        state_q      <= DATA;
                        arvalid_q    <= 1'b0;
`ifdef AXI_ARB_RR_EN
                        last_grant_q <= grant_q;
`endif
                    end
                end
                DATA: begin
                    if (m_rvalid && m_rready && m_rlast) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    arvalid_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign sel0_c = (state_q == DATA) & ~grant_q;
    assign sel1_c = (state_q == DATA) &  grant_q;

    // AR channel: payload muxed from the granted requester, zero when idle.
    assign m_arvalid  = arvalid_q;
    assign m_arid     = arvalid_q ? (grant_q ? s1_arid   : s0_arid)   : '0;
    assign m_araddr   = arvalid_q ? (grant_q ? s1_araddr : s0_araddr) : '0;
    assign m_arinfo   = arvalid_q ? (grant_q ? s1_arinfo : s0_arinfo) : '0;
    assign s0_arready = arvalid_q & ~grant_q & m_arready;
    assign s1_arready = arvalid_q &  grant_q & m_arready;

    // R channel: routed by grant only; a response outside DATA is held off.
    assign m_rready  = (sel0_c & s0_rready) | (sel1_c & s1_rready);

    assign s0_rvalid = sel0_c & m_rvalid;
    assign s0_rid    = sel0_c ? m_rid   : '0;
    assign s0_rdata  = sel0_c ? m_rdata : '0;
    assign s0_rresp  = sel0_c ? m_rresp : '0;
    assign s0_rlast  = sel0_c & m_rlast;

    assign s1_rvalid = sel1_c & m_rvalid;
    assign s1_rid    = sel1_c ? m_rid   : '0;
    assign s1_rdata  = sel1_c ? m_rdata : '0;
    assign s1_rresp  = sel1_c ? m_rresp : '0;
    assign s1_rlast  = sel1_c & m_rlast;

    assign busy = busy_q;

endmodule
